// File: rtl/vector_normalize_if.sv
// Start/result bundle for the block-floating-point normalizer.
// master drives start/in_vector; slave returns busy/done/out_vector/shift_amt.
`ifndef MAX_NEURONS
`define MAX_NEURONS 4
`endif

interface vector_normalize_if #(
    parameter int N     = `MAX_NEURONS,
    parameter int WIDTH = 16,
    parameter int SW    = $clog2(WIDTH)
);
    logic                 start;
    logic [N*WIDTH-1:0]   in_vector;
    logic                 busy;
    logic                 done;
    logic [N*WIDTH-1:0]   out_vector;
    logic [SW-1:0]        shift_amt;

    modport master (
        output start,
        output in_vector,
        input  busy,
        input  done,
        input  out_vector,
        input  shift_amt
    );

    modport slave (
        input  start,
        input  in_vector,
        output busy,
        output done,
        output out_vector,
        output shift_amt
    );
endinterface

// File: rtl/vector_normalize.sv
// Sequential block-floating-point normalizer: finds the largest common left
// shift of N signed elements that loses no significant bits, applies it and
// reports it. Ports: clk, rst_n (async active-low), bus (slave modport:
// start, in_vector -> busy, done, out_vector, shift_amt).
// Optional build macro VECTOR_NORMALIZE_HEADROOM_EN keeps one guard bit.
`ifndef MAX_NEURONS
`define MAX_NEURONS 4
`endif

module vector_normalize #(
    parameter int N     = `MAX_NEURONS,
    parameter int WIDTH = 16,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vector_normalize_if.slave     bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SCAN  = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_APPLY = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q;
    logic [WIDTH-1:0] buf_q [N];
    logic [WIDTH-2:0] acc_q;
    logic [IW-1:0]    idx_q;
    logic [SW-1:0]    shift_q;

    logic [WIDTH-1:0] cur;
    logic [WIDTH-2:0] mag;
    logic [SW-1:0]    lzc;
    logic [SW-1:0]    shift_nxt;
    logic             found;
    logic             last;

    assign cur  = buf_q[idx_q];
    // Ones-complement magnitude: -1 maps to 0, most negative maps to all ones.
    assign mag  = cur[WIDTH-2:0] ^ {(WIDTH-1){cur[WIDTH-1]}};
    assign last = (idx_q == IW'(N - 1));

    always_comb begin
        lzc   = '0;
        found = 1'b0;
        for (int b = WIDTH - 2; b >= 0; b--) begin
            if (!found) begin
                if (acc_q[b]) found = 1'b1;
                else          lzc   = lzc + SW'(1);
            end
        end
    end

    always_comb begin
        shift_nxt = lzc;
`ifdef VECTOR_NORMALIZE_HEADROOM_EN
        if (lzc != '0) shift_nxt = lzc - SW'(1);
`endif
        // All elements 0 or -1: nothing to normalize.
        if (acc_q == '0) shift_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            for (int i = 0; i < N; i++) buf_q[i] <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < N; i++)
                            buf_q[i] <= bus.in_vector[i*WIDTH +: WIDTH];
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    acc_q <= acc_q | mag;
                    if (last) state_q <= S_CALC;
                    else      idx_q   <= idx_q + IW'(1);
                end
                S_CALC: begin
                    shift_q <= shift_nxt;
                    idx_q   <= '0;
                    state_q <= S_APPLY;
                end
                S_APPLY: begin
                    buf_q[idx_q] <= $signed(cur) <<< shift_q;
                    if (last) state_q <= S_DONE;
                    else      idx_q   <= idx_q + IW'(1);
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_out
        assign bus.out_vector[g*WIDTH +: WIDTH] = buf_q[g];
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.shift_amt = shift_q;
endmodule

// File: tb/tb_vector_normalize.sv
// Scoreboard bench for vector_normalize (N=4, WIDTH=16): directed vectors
// with hand-computed results, held start, in_vector churn and mid-run reset.
`timescale 1ns/1ps
module tb_vector_normalize;
    localparam int N = 4;
    localparam int W = 16;
    localparam int SW = 4;

    typedef struct {
        logic [SW-1:0]  shift;
        logic [N*W-1:0] vec;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   asserts = 0;
    int   fails = 0;
    int   cyc = 0;
    int   accepts = 0;
    int   last_acc = 0;
    int   acc_cycs[$];
    bit   prev_busy = 1'b0;
    exp_t sb[$];

    vector_normalize_if #(.N(N), .WIDTH(W), .SW(SW)) bus ();

    vector_normalize #(.N(N), .WIDTH(W), .SW(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        asserts++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [N*W-1:0] pk(input logic [W-1:0] e0,
        input logic [W-1:0] e1, input logic [W-1:0] e2,
        input logic [W-1:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    // Monitor: track accepts, pop scoreboard on every done pulse.
    always @(negedge clk) begin
        if (rst_n && bus.busy && !prev_busy) begin
            accepts++;
            last_acc = cyc;
            acc_cycs.push_back(cyc);
        end
        prev_busy = bus.busy;
        if (bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("shift_amt", 64'(bus.shift_amt), 64'(e.shift));
                chk("out_vector", bus.out_vector, e.vec);
                chk("latency", 64'(cyc - last_acc), 64'(2*N + 1));
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (bus.busy && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (bus.busy) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic run(input logic [N*W-1:0] v, input logic [SW-1:0] s,
                       input logic [N*W-1:0] r);
        exp_t e;
        wait_idle();
        @(negedge clk);
        e.shift = s;
        e.vec = r;
        sb.push_back(e);
        bus.in_vector = v;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_vector = '1;
        wait_drain();
    endtask

    initial begin
        exp_t e;
        int a0;
        bus.start = 1'b0;
        bus.in_vector = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_out", bus.out_vector, 64'd0);
        chk("rst_shift", 64'(bus.shift_amt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef VECTOR_NORMALIZE_HEADROOM_EN
        run(pk(16'h0003, 16'h0001, 16'h0000, 16'hFFFE), 4'd12,
            pk(16'h3000, 16'h1000, 16'h0000, 16'hE000));
        run(pk(16'h0003, 16'h0000, 16'h0000, 16'h0000), 4'd12,
            pk(16'h3000, 16'h0000, 16'h0000, 16'h0000));
        run(pk(16'h0001, 16'h0000, 16'h0000, 16'h0000), 4'd13,
            pk(16'h2000, 16'h0000, 16'h0000, 16'h0000));
`else
        run(pk(16'h0003, 16'h0001, 16'h0000, 16'hFFFE), 4'd13,
            pk(16'h6000, 16'h2000, 16'h0000, 16'hC000));
        run(pk(16'h0003, 16'h0000, 16'h0000, 16'h0000), 4'd13,
            pk(16'h6000, 16'h0000, 16'h0000, 16'h0000));
        run(pk(16'h0001, 16'h0000, 16'h0000, 16'h0000), 4'd14,
            pk(16'h4000, 16'h0000, 16'h0000, 16'h0000));
`endif
        run(pk(16'h4000, 16'h0001, 16'h8000, 16'h1234), 4'd0,
            pk(16'h4000, 16'h0001, 16'h8000, 16'h1234));
        run(pk(16'h0000, 16'h0000, 16'hFFFF, 16'h0000), 4'd0,
            pk(16'h0000, 16'h0000, 16'hFFFF, 16'h0000));

        // start held 20 cycles; in_vector churns during the first run.
        wait_idle();
        @(negedge clk);
        a0 = accepts;
        e.shift = 4'd0;
        e.vec = pk(16'h4000, 16'h0001, 16'h8000, 16'h1234);
        sb.push_back(e);
        sb.push_back(e);
        bus.in_vector = e.vec;
        bus.start = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (j == 3) bus.in_vector = pk(16'h0001, 0, 0, 0);
            if (j == 7) bus.in_vector = e.vec;
        end
        bus.start = 1'b0;
        wait_drain();
        chk("held_accepts", 64'(accepts - a0), 64'd2);
        if (acc_cycs.size() >= 2)
            chk("held_spacing", 64'(acc_cycs[$] - acc_cycs[$-1]),
                64'(2*N + 3));

        // Reset in the second SCAN cycle: no done, outputs cleared.
        wait_idle();
        @(negedge clk);
        bus.in_vector = pk(16'h0003, 0, 0, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_out", bus.out_vector, 64'd0);
        chk("abort_shift", 64'(bus.shift_amt), 64'd0);
        repeat (2) @(negedge clk);
        chk("abort_done", 64'(bus.done), 64'd0);
        rst_n = 1'b1;
        prev_busy = 1'b0;
        run(pk(16'h0100, 16'hFF00, 16'h0000, 16'h0000),
`ifdef VECTOR_NORMALIZE_HEADROOM_EN
            4'd5, pk(16'h2000, 16'hE000, 16'h0000, 16'h0000));
`else
            4'd6, pk(16'h4000, 16'hC000, 16'h0000, 16'h0000));
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end
endmodule
